// File: rtl/axis_atomic_fi.sv
`default_nettype none
// ============================================================================
//  Module   : axis_atomic_fi
//  Purpose  : Fan-in of two AXI-Stream channels (A, B) into one {B, A} word
//             with a per-channel presence mask; a lone beat waits a bounded
//             time for its partner. Optional macro: AXIS_ATOMIC_FI_TIMEOUT_EN
//  Revision : 1.0 - initial release
// ============================================================================
module axis_atomic_fi #(
    parameter int CHA_BITS    = 8,
    parameter int CHB_BITS    = 8,
    parameter int WAIT_CYCLES = 3,
    parameter int WAIT_BITS   = 4
) (
    input  logic                         s_ul_clk,
    input  logic                         reset_n,
    output logic                         s_axis_cha_tready,
    input  logic                         s_axis_cha_tvalid,
    input  logic [CHA_BITS-1:0]          s_axis_cha_tdata,
    output logic                         s_axis_chb_tready,
    input  logic                         s_axis_chb_tvalid,
    input  logic [CHB_BITS-1:0]          s_axis_chb_tdata,
    input  logic                         m_axis_comb_tready,
    output logic                         m_axis_comb_tvalid,
    output logic [CHA_BITS+CHB_BITS-1:0] m_axis_comb_tdata,
    output logic [1:0]                   m_axis_comb_tuser
);

    logic                         r_rdy_en;
    logic                         r_cha_full;
    logic                         r_chb_full;
    logic [CHA_BITS-1:0]          r_cha_data;
    logic [CHB_BITS-1:0]          r_chb_data;
    logic                         r_out_valid;
    logic [CHA_BITS+CHB_BITS-1:0] r_out_data;
    logic [1:0]                   r_out_user;

    logic                         w_cha_acc;
    logic                         w_chb_acc;
    logic                         w_out_free;
    logic                         w_load;
    logic [CHA_BITS+CHB_BITS-1:0] w_comb_data;

    // Oversized WAIT_CYCLES can never be reached by the timer; this branch
    // only marks that configuration as illegal.
    if (WAIT_CYCLES >= (2 ** WAIT_BITS)) begin : g_wait_cfg_illegal
    end

    // r_rdy_en keeps both slots closed during reset and until the first edge after release.
    assign s_axis_cha_tready  = r_rdy_en & ~r_cha_full;
    assign s_axis_chb_tready  = r_rdy_en & ~r_chb_full;
    assign w_cha_acc          = s_axis_cha_tvalid & s_axis_cha_tready;
    assign w_chb_acc          = s_axis_chb_tvalid & s_axis_chb_tready;
    assign w_out_free         = ~r_out_valid | m_axis_comb_tready;
    assign w_comb_data        = {r_chb_data & {CHB_BITS{r_chb_full}},
                                 r_cha_data & {CHA_BITS{r_cha_full}}};

    assign m_axis_comb_tvalid = r_out_valid;
    assign m_axis_comb_tdata  = r_out_data;
    assign m_axis_comb_tuser  = r_out_user;

`ifdef AXIS_ATOMIC_FI_TIMEOUT_EN
    localparam logic [WAIT_BITS-1:0] c_wait = WAIT_BITS'(WAIT_CYCLES);

    logic [WAIT_BITS-1:0] r_timer;
    logic                 w_one_full;

    assign w_one_full = r_cha_full ^ r_chb_full;
    assign w_load     = w_out_free &
                        ((r_cha_full & r_chb_full) | (w_one_full & (r_timer == c_wait)));

    // A partner accepted on a lone-beat load edge restarts its wait from zero.
    always_ff @(posedge s_ul_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_load || !(r_cha_full || r_chb_full)) begin
            r_timer <= '0;
        end else if (w_one_full && (r_timer < c_wait)) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_load = w_out_free & (r_cha_full | r_chb_full);
`endif

    always_ff @(posedge s_ul_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_en   <= 1'b0;
            r_cha_full <= 1'b0;
            r_chb_full <= 1'b0;
            r_cha_data <= '0;
            r_chb_data <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_cha_full <= (r_cha_full & ~w_load) | w_cha_acc;
            r_chb_full <= (r_chb_full & ~w_load) | w_chb_acc;
            if (w_cha_acc) begin
                r_cha_data <= s_axis_cha_tdata;
            end
            if (w_chb_acc) begin
                r_chb_data <= s_axis_chb_tdata;
            end
        end
    end

    always_ff @(posedge s_ul_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= 2'b00;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_comb_data;
            r_out_user  <= {r_chb_full, r_cha_full};
        end else if (m_axis_comb_tready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
